// File: rtl/lsu_stage_if.sv
// rtl/lsu_stage_if.sv - single-outstanding req/ack data bus between lsu_stage and memory
interface lsu_stage_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/lsu_stage.sv
// rtl/lsu_stage.sv - load/store unit with lane steering, load extension, misalign check; optional bus timeout via LSU_TIMEOUT_EN
module lsu_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [4:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misalign,
    output logic        timeout,
    lsu_stage_if.master bus
);

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    logic [1:0]  state;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        is_load;
    logic        is_store;
    logic        start;
    logic        unaligned;
    logic        go;
    logic        to_hit;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] rd_shift;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] fmt_data;

    // Decode the instruction in execute and qualify a start / misaligned reject
    always_comb begin
        is_load   = (opcode == OP_LOAD)  && (func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        is_store  = (opcode == OP_STORE) && (func3 inside {3'b000, 3'b001, 3'b010});
        start     = valid && (state == S_IDLE) && (is_load || is_store);
        unaligned = ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00)) ||
                    ((func3[1:0] == 2'b01) && addr[0]);
        go        = start && !unaligned;
        misalign  = start && unaligned;
        stall     = !rst && (go || (state == S_BUSY));
    end

    // Byte enables and lane-replicated write data for the access being launched
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = store_data;
        case (func3[1:0])
            2'b00: begin
                wdata_next = {4{store_data[7:0]}};
                if (is_store) be_next = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                wdata_next = {2{store_data[15:0]}};
                if (is_store) be_next = 4'b0011 << {addr[1], 1'b0};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = store_data;
            end
        endcase
    end

    // Select the addressed lane of the read word and sign/zero extend it
    always_comb begin
        rd_shift = bus.bus_rdata >> {off_q, 3'b000};
        rd_byte  = rd_shift[7:0];
        rd_half  = off_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        case (f3_q)
            3'b000:  fmt_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  fmt_data = {{16{rd_half[15]}}, rd_half};
            3'b100:  fmt_data = {24'd0, rd_byte};
            3'b101:  fmt_data = {16'd0, rd_half};
            default: fmt_data = bus.bus_rdata;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    assign to_hit = (state == S_BUSY) && (cnt == CW'(TIMEOUT_CYCLES));

    // Count BUSY cycles (1 in the first) and flag an unacknowledged access
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                S_IDLE:  cnt <= go ? CW'(1) : '0;
                S_BUSY: begin
                    cnt     <= cnt + 1'b1;
                    timeout <= to_hit && !bus.bus_ack;
                end
                default: cnt <= cnt;
            endcase
        end
    end
`else
    assign to_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    // Access FSM: launch on aligned start, hold the bus until ack, retire in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            bus.bus_be    <= '0;
            load_data     <= '0;
            load_valid    <= 1'b0;
            f3_q          <= '0;
            off_q         <= '0;
        end else begin
            load_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        state         <= S_BUSY;
                        bus.bus_req   <= 1'b1;
                        bus.bus_we    <= is_store;
                        bus.bus_addr  <= {addr[31:2], 2'b00};
                        bus.bus_be    <= be_next;
                        bus.bus_wdata <= wdata_next;
                        f3_q          <= func3;
                        off_q         <= addr[1:0];
                    end
                end
                S_BUSY: begin
                    if (bus.bus_ack) begin
                        bus.bus_req <= 1'b0;
                        state       <= S_DONE;
                        if (!bus.bus_we) begin
                            load_data  <= fmt_data;
                            load_valid <= 1'b1;
                        end
                    end else if (to_hit) begin
                        bus.bus_req <= 1'b0;
                        state       <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_stage.sv
// tb/tb_lsu_stage.sv - randomized self-checking bench for lsu_stage against a behavioural model
module tb_lsu_stage;
    localparam int TO = 4;
`ifdef LSU_TIMEOUT_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [4:0]  opcode;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misalign;
    logic        timeout;

    lsu_stage_if bus ();

    lsu_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid),
        .opcode     (opcode),
        .func3      (func3),
        .addr       (addr),
        .store_data (store_data),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .misalign   (misalign),
        .timeout    (timeout),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] ref_ld = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] b;
        logic [31:0] h;
        b = (rd >> (8 * int'(a[1:0]))) & 32'hFF;
        h = (rd >> (16 * int'(a[1]))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input bit st, input logic [2:0] f3, input logic [31:0] a);
        if (!st || f3 == 3'd2) return 4'hF;
        if (f3 == 3'd0) return 4'(1 << int'(a[1:0]));
        return 4'(3 << int'(a[1:0]));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
        if (f3 == 3'd0) return (sd & 32'hFF) * 32'h0101_0101;
        if (f3 == 3'd1) return (sd & 32'hFFFF) * 32'h0001_0001;
        return sd;
    endfunction

    // Present one instruction and act as the bus slave, acking after 'waits' BUSY cycles
    task automatic run_access(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input int waits, input logic [31:0] rd);
        bit is_ld, is_st, legal, mis, timed;
        int n_busy;
        is_ld = (op == 5'd0);
        is_st = (op == 5'd8);
        legal = is_ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) :
                is_st ? (f3 inside {3'd0, 3'd1, 3'd2}) : 1'b0;
        mis   = legal && (((f3 % 4) == 2 && (a % 4) != 0) || ((f3 % 4) == 1 && (a % 2) != 0));
        valid = 1'b1; opcode = op; func3 = f3; addr = a; store_data = sd;
        bus.bus_ack = 1'($urandom % 2);
        bus.bus_rdata = $urandom;
        #1;
        check("misalign", misalign, mis);
        check("stall_start", stall, legal && !mis);
        if (!legal || mis) begin
            @(negedge clk);
            valid = 1'b0; bus.bus_ack = 1'b0;
            #1;
            check("noacc_req", bus.bus_req, 1'b0);
            check("noacc_stall", stall, 1'b0);
            check("noacc_lv", load_valid, 1'b0);
            check("noacc_ld", load_data, ref_ld);
            return;
        end
        timed  = TEN && (waits >= TO);
        n_busy = timed ? TO : waits + 1;
        for (int k = 0; k < n_busy; k++) begin
            @(negedge clk);
            bus.bus_ack   = (k == waits);
            bus.bus_rdata = (k == waits) ? rd : $urandom;
            #1;
            check("busy_req", bus.bus_req, 1'b1);
            check("busy_stall", stall, 1'b1);
            check("busy_addr", bus.bus_addr, a & 32'hFFFF_FFFC);
            check("busy_we", bus.bus_we, is_st);
            check("busy_be", bus.bus_be, model_be(is_st, f3, a));
            if (is_st) check("busy_wdata", bus.bus_wdata, model_wdata(f3, sd));
        end
        @(negedge clk);
        bus.bus_ack = 1'($urandom % 2);
        #1;
        if (is_ld && !timed) ref_ld = model_load(f3, a, rd);
        check("done_stall", stall, 1'b0);
        check("done_req", bus.bus_req, 1'b0);
        check("done_lv", load_valid, is_ld && !timed);
        check("done_timeout", timeout, timed);
        check("done_ld", load_data, ref_ld);
        @(negedge clk);
        valid = 1'b0; bus.bus_ack = 1'b0;
        #1;
        check("after_stall", stall, 1'b0);
        check("after_req", bus.bus_req, 1'b0);
        check("after_lv", load_valid, 1'b0);
        check("after_timeout", timeout, 1'b0);
        check("after_ld", load_data, ref_ld);
    endtask

    // Start an aligned lw, assert reset in BUSY cycle 'nbusy' together with an ack
    task automatic reset_in_busy(input int nbusy);
        valid = 1'b1; opcode = 5'd0; func3 = 3'd2; addr = $urandom & 32'hFFFF_FFFC;
        bus.bus_ack = 1'b0;
        #1;
        check("rb_stall_start", stall, 1'b1);
        for (int k = 1; k <= nbusy; k++) begin
            @(negedge clk);
            if (k < nbusy) begin
                bus.bus_ack = 1'b0;
                #1;
                check("rb_req", bus.bus_req, 1'b1);
                check("rb_stall", stall, 1'b1);
            end else begin
                rst = 1'b1; bus.bus_ack = 1'b1; bus.bus_rdata = $urandom | 32'h1;
                #1;
                check("rb_stall_rst", stall, 1'b0);
            end
        end
        @(negedge clk);
        rst = 1'b0; valid = 1'b0; bus.bus_ack = 1'b0;
        #1;
        ref_ld = '0;
        check("rb_req_after", bus.bus_req, 1'b0);
        check("rb_stall_after", stall, 1'b0);
        check("rb_lv_after", load_valid, 1'b0);
        check("rb_ld_after", load_data, ref_ld);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b1; opcode = 5'd0; func3 = 3'd2; addr = 32'h100; store_data = '0;
        bus.bus_ack = 1'b0; bus.bus_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", bus.bus_req, 1'b0);
        check("rst_we", bus.bus_we, 1'b0);
        check("rst_addr", bus.bus_addr, 32'h0);
        check("rst_wdata", bus.bus_wdata, 32'h0);
        check("rst_be", bus.bus_be, 4'h0);
        check("rst_ld", load_data, 32'h0);
        check("rst_lv", load_valid, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_stall", stall, 1'b0);
        @(negedge clk);
        rst = 1'b0; valid = 1'b0;
        #1;

        run_access(5'd0, 3'd0, 32'h0000_1003, 32'h0, 2, 32'h80FF_1234);
        check("tp_lb", load_data, 32'hFFFF_FF80);
        run_access(5'd0, 3'd5, 32'h0000_2002, 32'h0, 0, 32'h8001_0000);
        check("tp_lhu", load_data, 32'h0000_8001);
        run_access(5'd8, 3'd0, 32'h0000_3001, 32'h1234_56AB, 1, $urandom);
        check("tp_sb_keep_ld", load_data, 32'h0000_8001);
        run_access(5'd8, 3'd2, 32'h0000_4002, 32'h0, 0, $urandom);
        if (TEN) run_access(5'd0, 3'd2, 32'h0000_5000, 32'h0, 100, $urandom);
        else     reset_in_busy(20);
        reset_in_busy(2);

        for (int i = 0; i < 60; i++) begin
            logic [4:0] op;
            case ($urandom % 4)
                0, 2:    op = 5'd0;
                1:       op = 5'd8;
                default: op = 5'($urandom);
            endcase
            if ($urandom % 12 == 0) reset_in_busy(1 + int'($urandom % 3));
            else run_access(op, 3'($urandom), $urandom, $urandom, int'($urandom % 6), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
